tipi_shift_load: RTL

TIPI_SHIFT_LOAD -- requirements
Module: tipi_shift_load

---
 rtl/tipi_pkg.sv | 16 +
 rtl/tipi_sync_edge.sv | 28 ++
 rtl/tipi_shift_load.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tipi_pkg.sv
// Shared definitions for the TIPI Pi-to-TI byte path: register selects,
// read-port FSM states and byte/bit-count constants.
package tipi_pkg;

  localparam int          BYTE_W       = 8;
  localparam logic        SEL_TD       = 1'b0;
  localparam logic        SEL_TC       = 1'b1;
  localparam logic [3:0]  BIT_CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/tipi_sync_edge.sv
// N-flop synchronizer for one asynchronous Pi-side line, with a one-clk
// pulse on each synchronized rising edge.
module tipi_sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [N-1:0] r_sync;
  logic         r_prev;

  // Synchronizer chain plus one flop of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {N{1'b0}};
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_async};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_rise = r_sync[N-1] & ~r_prev;

endmodule

// File: rtl/tipi_shift_load.sv
// Pi serial shifter feeding the TD/TC registers, plus the TI read port that
// drives a downstream tristate buffer. Optional macro: TIPI_SHIFT_COUNT_CHECK_EN.
module tipi_shift_load
  import tipi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_sclk,
  input  logic              r_sdata,
  input  logic              r_le,
  input  logic              r_sel,
  input  logic              ti_rd_req,
  input  logic              ti_rd_reg,
  output logic              t_en,
  output logic [BYTE_W-1:0] dout,
  output logic              load_pulse
);

  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic                   w_sclk_rise;
  logic                   w_le_rise;
  logic                   w_sdata;
  logic                   w_sel;
  logic                   w_commit;
  logic                   w_defer;
  logic [BYTE_W-1:0]      r_shreg;
  logic [3:0]             r_bit_cnt;
  logic [BYTE_W-1:0]      r_td;
  logic [BYTE_W-1:0]      r_tc;
  logic [BYTE_W-1:0]      r_pend;
  logic [BYTE_W-1:0]      r_dout;
  logic [BYTE_W-1:0]      w_td_nxt;
  logic [BYTE_W-1:0]      w_tc_nxt;
  logic [BYTE_W-1:0]      w_pend_nxt;
  rd_state_e              r_state;
  rd_state_e              w_state_nxt;
  logic                   r_rd_sel;
  logic                   w_rd_sel_nxt;
  logic                   r_t_en;
  logic                   r_load_pulse;
  logic                   w_load_nxt;

  tipi_sync_edge #(.N(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (r_sclk),
    .o_rise  (w_sclk_rise)
  );

  tipi_sync_edge #(.N(SYNC_STAGES)) u_sync_le (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (r_le),
    .o_rise  (w_le_rise)
  );

  // Data and select lines share the strobe's latency so they line up with its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sdata_sync <= {SYNC_STAGES{1'b0}};
      r_sel_sync   <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], r_sdata};
      r_sel_sync   <= {r_sel_sync[SYNC_STAGES-2:0], r_sel};
    end
  end

  assign w_sdata = r_sdata_sync[SYNC_STAGES-1];
  assign w_sel   = r_sel_sync[SYNC_STAGES-1];

`ifdef TIPI_SHIFT_COUNT_CHECK_EN
  assign w_commit = w_le_rise & (r_bit_cnt == BIT_CNT_FULL);
`else
  assign w_commit = w_le_rise;
`endif

  // A commit aimed at the byte on the bus is parked until the read ends
  assign w_defer = w_commit & (r_state != IDLE) & ti_rd_req & (w_sel == r_rd_sel);

  // Shift register and saturating bit counter; a commit sees the pre-shift byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= {BYTE_W{1'b0}};
      r_bit_cnt <= 4'd0;
    end else begin
      if (w_sclk_rise) begin
        r_shreg <= {r_shreg[BYTE_W-2:0], w_sdata};
      end else begin
        r_shreg <= r_shreg;
      end
      if (w_le_rise) begin
        r_bit_cnt <= w_sclk_rise ? 4'd1 : 4'd0;
      end else if (w_sclk_rise && (r_bit_cnt != BIT_CNT_FULL)) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  // Read FSM next state and register/pending updates
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_sel_nxt = r_rd_sel;
    w_td_nxt     = r_td;
    w_tc_nxt     = r_tc;
    w_pend_nxt   = r_pend;
    w_load_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ti_rd_req) begin
          w_state_nxt  = DRIVE;
          w_rd_sel_nxt = ti_rd_reg;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (!ti_rd_req) begin
          w_state_nxt = IDLE;
        end else if (w_defer) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      HOLD: begin
        if (!ti_rd_req) begin
          w_state_nxt = IDLE;
          w_load_nxt  = 1'b1;
          if (r_rd_sel == SEL_TC) begin
            w_tc_nxt = r_pend;
          end else begin
            w_td_nxt = r_pend;
          end
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A fresh commit is applied after any pending one, so the newest byte wins
    if (w_defer) begin
      w_pend_nxt = r_shreg;
    end else if (w_commit) begin
      w_load_nxt = 1'b1;
      if (w_sel == SEL_TD) begin
        w_td_nxt = r_shreg;
      end else begin
        w_tc_nxt = r_shreg;
      end
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // State, registers and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_sel     <= SEL_TD;
      r_td         <= {BYTE_W{1'b0}};
      r_tc         <= {BYTE_W{1'b0}};
      r_pend       <= {BYTE_W{1'b0}};
      r_t_en       <= 1'b0;
      r_dout       <= {BYTE_W{1'b0}};
      r_load_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_sel     <= w_rd_sel_nxt;
      r_td         <= w_td_nxt;
      r_tc         <= w_tc_nxt;
      r_pend       <= w_pend_nxt;
      r_t_en       <= (w_state_nxt != IDLE);
      r_dout       <= ((w_state_nxt != IDLE) && (w_rd_sel_nxt == SEL_TC)) ? w_tc_nxt : w_td_nxt;
      r_load_pulse <= w_load_nxt;
    end
  end

  assign t_en       = r_t_en;
  assign dout       = r_dout;
  assign load_pulse = r_load_pulse;

endmodule
